datapath_mem_responder: RTL and testbench

- Responder end of the datapath-to-cache request interface. It serves the pipeline's instruction-fetch and data load/store requests from a single-ported word RAM.
- Arbitrates between I and D requests, runs the RAM handshake, and returns ihit/dhit pulses with the matching load data.
- Sits between the datapath and the memory model or bus; it replaces a pass-through memory control in single-core builds.

---
 rtl/datapath_mem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_datapath_mem_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_mem_responder.sv
// ============================================================================
// datapath_mem_responder
// ----------------------------------------------------------------------------
// Purpose
//   Responder end of the datapath-to-cache request interface. Serves the
//   pipeline's instruction fetches and data loads/stores from a single-ported
//   word RAM. Arbitrates I against D, runs the RAM handshake, and returns
//   one-cycle ihit/dhit pulses with the matching load data.
//
// Parameters
//   WORD_W   data and address width in bits
//   TIMEOUT  RAM wait cycles before an access is aborted with err
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   halt                datapath halted: no new requests are accepted
//   imemREN, imemaddr   fetch request and address
//   ihit, imemload      fetch-complete pulse and instruction (valid with ihit)
//   dmemREN, dmemWEN    data read / write request (write wins if both set)
//   dmemaddr, dmemstore data address and write data
//   dhit, dmemload      data-complete pulse and read data (held between reads)
//   ramREN, ramWEN      RAM strobes
//   ramaddr, ramstore   RAM word address (bits [1:0] zero) and write data
//   ramload, ramready   RAM read data and access-done flag
//   err                 sticky access-timeout flag, cleared only by reset
//
// Handshake
//   A RAM access is open while ramREN or ramWEN is high. The strobes, address
//   and write data stay constant until the cycle in which ramready=1; that
//   cycle completes the access and the strobes drop on the next clock edge.
//   ihit/dhit are asserted only in that completing cycle, and only if the
//   datapath still holds its request. The FSM always passes through IDLE
//   between two accesses.
//
// Build option
//   IFETCH_BUF_EN  adds a one-entry fetch buffer (valid, word tag, data) that
//                  answers a repeated fetch from IDLE in the same cycle.
//
// The FSM state is kept in the internal signal `state` (state_t) for probing.
// ============================================================================
module datapath_mem_responder #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    // instruction fetch side
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    // data side
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready,
    // status
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DACC   = 2'd1,
        IACC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    // Last wait count at which the strobes are still driven; reaching it
    // without ramready aborts the access, so strobes are up TIMEOUT cycles.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [WORD_W-1:0] WORD_MASK = ~WORD_W'(3);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                err_q;
    logic                from_dacc;   // first IDLE cycle after a data access
    logic [WORD_W-1:0]   acc_addr;    // word address of the open access
    logic [WORD_W-1:0]   acc_store;
    logic                acc_write;
    logic [WORD_W-1:0]   dload_q;

    logic                d_req;
    logic                in_acc;
    logic                d_done;
    logic                i_done;
    logic                i_ram_hit;
    logic                buf_hit;
    logic [WORD_W-1:0]   buf_data_out;

    assign d_req     = dmemREN | dmemWEN;
    assign in_acc    = (state == DACC) || (state == IACC);
    assign d_done    = (state == DACC) && ramready;
    assign i_done    = (state == IACC) && ramready;
    assign i_ram_hit = i_done && imemREN;

    // ------------------------------------------------------------------------
    // Control FSM. Address, write data and direction are captured when an
    // access opens, so a request dropped mid-access (flush) still lets the
    // RAM transaction finish cleanly; only the hit pulse is suppressed.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            from_dacc <= 1'b0;
            acc_addr  <= '0;
            acc_store <= '0;
            acc_write <= 1'b0;
            dload_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    from_dacc <= 1'b0;
                    if (!halt && imemREN && from_dacc && !buf_hit) begin
                        // A fetch that waited behind a data access goes next,
                        // even if another data request is already pending.
                        state     <= IACC;
                        acc_addr  <= imemaddr & WORD_MASK;
                        acc_write <= 1'b0;
                    end else if (!halt && d_req) begin
                        state     <= DACC;
                        acc_addr  <= dmemaddr & WORD_MASK;
                        acc_store <= dmemstore;
                        acc_write <= dmemWEN;
                    end else if (!halt && imemREN && !buf_hit) begin
                        state     <= IACC;
                        acc_addr  <= imemaddr & WORD_MASK;
                        acc_write <= 1'b0;
                    end else if (halt) begin
                        state <= HALTED;
                    end
                end

                DACC, IACC: begin
                    if (ramready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        from_dacc <= (state == DACC);
                        // Load data is only committed when the read is
                        // actually delivered to the datapath.
                        if ((state == DACC) && !acc_write && d_req) begin
                            dload_q <= ramload;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        err_q     <= 1'b1;
                        from_dacc <= (state == DACC);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional one-entry fetch buffer.
    // ------------------------------------------------------------------------
`ifdef IFETCH_BUF_EN
    logic              buf_valid;
    logic [WORD_W-3:0] buf_tag;
    logic [WORD_W-1:0] buf_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (i_done) begin
            // Refill on every completed RAM fetch, flushed or not: the RAM
            // word is valid either way.
            buf_valid <= 1'b1;
            buf_tag   <= acc_addr[WORD_W-1:2];
            buf_data  <= ramload;
        end else if ((state == DACC) && acc_write &&
                     (acc_addr[WORD_W-1:2] == buf_tag)) begin
            // A store to the buffered word makes the copy stale.
            buf_valid <= 1'b0;
        end
    end

    // Served only from IDLE and only when no data request competes.
    assign buf_hit = (state == IDLE) && !halt && imemREN && !d_req &&
                     buf_valid && (buf_tag == imemaddr[WORD_W-1:2]);
    assign buf_data_out = buf_data;
`else
    assign buf_hit      = 1'b0;
    assign buf_data_out = '0;
`endif

    // ------------------------------------------------------------------------
    // Output decode from the registered state and captured access fields.
    // ------------------------------------------------------------------------
    assign ihit     = i_ram_hit | buf_hit;
    assign imemload = i_ram_hit ? ramload : (buf_hit ? buf_data_out : '0);

    assign dhit     = d_done && d_req;
    // Bypass so a completing read is visible in its own hit cycle.
    assign dmemload = (dhit && !acc_write) ? ramload : dload_q;

    assign ramREN   = in_acc && !((state == DACC) && acc_write);
    assign ramWEN   = (state == DACC) && acc_write;
    assign ramaddr  = in_acc ? acc_addr : '0;
    assign ramstore = ramWEN ? acc_store : '0;

    assign err      = err_q;

endmodule

// File: tb/tb_datapath_mem_responder.sv
// ============================================================================
// tb_datapath_mem_responder
// ----------------------------------------------------------------------------
// Bench for datapath_mem_responder: behavioural RAM with programmable
// latency, hit monitor popping an expected-result queue, directed scenarios.
// ============================================================================
module tb_datapath_mem_responder;

  localparam int W  = 32;
  localparam int TO = 40;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         halt = 1'b0;
  logic         imemREN = 1'b0;
  logic [W-1:0] imemaddr = '0;
  logic         ihit;
  logic [W-1:0] imemload;
  logic         dmemREN = 1'b0;
  logic         dmemWEN = 1'b0;
  logic [W-1:0] dmemaddr = '0;
  logic [W-1:0] dmemstore = '0;
  logic         dhit;
  logic [W-1:0] dmemload;
  logic         ramREN;
  logic         ramWEN;
  logic [W-1:0] ramaddr;
  logic [W-1:0] ramstore;
  logic [W-1:0] ramload = '0;
  logic         ramready = 1'b0;
  logic         err;

  datapath_mem_responder #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural RAM: ready after ram_lat strobe cycles, never if ram_stall.
  // --------------------------------------------------------------------------
  logic [W-1:0] mem [bit [31:0]];
  int ram_wait = 0;
  int ram_lat = 1;
  bit ram_stall = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (ramREN || ramWEN) ram_wait = ram_wait + 1;
    else ram_wait = 0;
    ramready = (ramREN || ramWEN) && !ram_stall && (ram_wait >= ram_lat);
    ramload = (ramREN && mem.exists(ramaddr)) ? mem[ramaddr] : '0;
  end

  always @(negedge CLK) begin
    if (ramWEN && ramready) mem[ramaddr] = ramstore;
  end

  // --------------------------------------------------------------------------
  // Scoreboard: entries are {is_data, value}, in expected completion order.
  // --------------------------------------------------------------------------
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;
  logic [W-1:0] model_dload = '0;
  int n_hits = 0;
  logic [W-1:0] last_addr;
  logic [W-1:0] last_store;
  logic last_ren;
  logic last_wen;

  always @(negedge CLK) begin
    if (!RST && (ihit || dhit)) begin
      n_hits++;
      last_addr = ramaddr;
      last_store = ramstore;
      last_ren = ramREN;
      last_wen = ramWEN;
      check("hit_exclusive", {63'b0, ihit & dhit}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_hit", {62'b0, ihit, dhit}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hit_kind", {63'b0, dhit}, {63'b0, mon_e[W]});
        check("hit_data", {32'b0, (dhit ? dmemload : imemload)}, {32'b0, mon_e[W-1:0]});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_d_read(input logic [W-1:0] value);
    model_dload = value;
    exp_q.push_back({1'b1, value});
  endtask

  task automatic push_d_write();
    exp_q.push_back({1'b1, model_dload});
  endtask

  task automatic push_i(input logic [W-1:0] value);
    exp_q.push_back({1'b0, value});
  endtask

  task automatic wait_hits(input int n, input int budget);
    int target;
    int k;
    target = n_hits + n;
    k = 0;
    while (n_hits < target && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check("hit_wait", {63'b0, n_hits >= target}, 64'd1);
  endtask

  task automatic wait_strobe(input int budget);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge CLK);
      k++;
      seen = ramREN || ramWEN;
    end
    check("strobe_wait", {63'b0, seen}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ramREN"}, {63'b0, ramREN}, 64'd0);
    check({tag, "_ramWEN"}, {63'b0, ramWEN}, 64'd0);
    check({tag, "_ihit"}, {63'b0, ihit}, 64'd0);
    check({tag, "_dhit"}, {63'b0, dhit}, 64'd0);
    check({tag, "_err"}, {63'b0, err}, 64'd0);
    check({tag, "_ramaddr"}, {32'b0, ramaddr}, 64'd0);
    check({tag, "_ramstore"}, {32'b0, ramstore}, 64'd0);
    check({tag, "_dmemload"}, {32'b0, dmemload}, 64'd0);
    check({tag, "_imemload"}, {32'b0, imemload}, 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int strobes;
    int k;

    // reset values
    repeat (2) @(negedge CLK);
    check_all_zero("rst");
    tick();
    RST = 1'b0;
    tick();

    // read, ready after two strobe cycles
    mem[32'h104] = 32'hDEAD_BEEF;
    ram_lat = 2;
    dmemREN = 1'b1;
    dmemaddr = 32'h104;
    push_d_read(32'hDEAD_BEEF);
    wait_hits(1, 20);
    check("rd_addr", {32'b0, last_addr}, 64'h104);
    check("rd_ren", {63'b0, last_ren}, 64'd1);
    check("rd_wen", {63'b0, last_wen}, 64'd0);
    tick();
    dmemREN = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    check("rd_hold", {32'b0, dmemload}, 64'hDEAD_BEEF);
    check("rd_dhit_low", {63'b0, dhit}, 64'd0);

    // contention: write and fetch together, data first
    ram_lat = 1;
    mem[32'h300] = 32'h1111_2222;
    tick();
    imemREN = 1'b1;
    imemaddr = 32'h300;
    dmemWEN = 1'b1;
    dmemaddr = 32'h200;
    dmemstore = 32'h55;
    push_d_write();
    push_i(32'h1111_2222);
    wait_hits(1, 20);
    check("ct_wen", {63'b0, last_wen}, 64'd1);
    check("ct_ren", {63'b0, last_ren}, 64'd0);
    check("ct_store", {32'b0, last_store}, 64'h55);
    check("ct_addr", {32'b0, last_addr}, 64'h200);
    tick();
    dmemWEN = 1'b0;
    wait_hits(1, 20);
    check("ct_iaddr", {32'b0, last_addr}, 64'h300);
    tick();
    imemREN = 1'b0;
    check("ct_mem", {32'b0, mem[32'h200]}, 64'h55);

    // fairness: data and fetch held together -> D, I, D
    mem[32'h304] = 32'h3333_4444;
    tick();
    dmemREN = 1'b1;
    dmemaddr = 32'h104;
    imemREN = 1'b1;
    imemaddr = 32'h304;
    push_d_read(32'hDEAD_BEEF);
    push_i(32'h3333_4444);
    push_d_read(32'hDEAD_BEEF);
    wait_hits(3, 40);
    tick();
    dmemREN = 1'b0;
    imemREN = 1'b0;
    check("fair_drained", exp_q.size(), 64'd0);

    // unaligned fetch
    mem[32'h4] = 32'hA5A5_0004;
    tick();
    imemREN = 1'b1;
    imemaddr = 32'h7;
    push_i(32'hA5A5_0004);
    wait_hits(1, 20);
    check("ua_addr", {32'b0, last_addr}, 64'h4);
    tick();
    imemREN = 1'b0;

    // timeout: RAM never ready
    tick();
    ram_stall = 1'b1;
    imemaddr = 32'h10;
    imemREN = 1'b1;
    strobes = 0;
    k = 0;
    while (k < 2 * TO + 20) begin
      @(negedge CLK);
      k++;
      if (ramREN) strobes++;
      else if (strobes > 0) break;
    end
    imemREN = 1'b0;
    check("to_strobes", strobes, TO);
    check("to_err", {63'b0, err}, 64'd1);
    check("to_strobes_off", {62'b0, ramREN, ramWEN}, 64'd0);
    ram_stall = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    check("to_err_sticky", {63'b0, err}, 64'd1);
    mem[32'h14] = 32'h0000_1414;
    tick();
    imemREN = 1'b1;
    imemaddr = 32'h14;
    push_i(32'h0000_1414);
    wait_hits(1, 20);
    tick();
    imemREN = 1'b0;

    // halt during a data access, ready after three strobe cycles
    ram_lat = 3;
    tick();
    dmemREN = 1'b1;
    dmemaddr = 32'h104;
    push_d_read(32'hDEAD_BEEF);
    wait_strobe(10);
    halt = 1'b1;
    imemREN = 1'b1;
    imemaddr = 32'h300;
    wait_hits(1, 20);
    tick();
    dmemREN = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge CLK);
      if (ramREN || ramWEN) strobes++;
    end
    check("halt_quiet", strobes, 0);

    // reset pulse clears everything, including the sticky err
    RST = 1'b1;
    #1;
    check_all_zero("rst2");
    halt = 1'b0;
    imemREN = 1'b0;
    model_dload = '0;
    tick();
    RST = 1'b0;
    tick();

    // reset in the middle of an access: no hit, outputs zero at once
    ram_lat = 5;
    dmemREN = 1'b1;
    dmemaddr = 32'h104;
    wait_strobe(10);
    RST = 1'b1;
    #1;
    check("mid_rst_ren", {63'b0, ramREN}, 64'd0);
    check("mid_rst_dhit", {63'b0, dhit}, 64'd0);
    check("mid_rst_dload", {32'b0, dmemload}, 64'd0);
    dmemREN = 1'b0;
    tick();
    RST = 1'b0;
    repeat (8) tick();

    // recovery read after the aborted access
    ram_lat = 1;
    mem[32'h108] = 32'hCAFE_0108;
    dmemREN = 1'b1;
    dmemaddr = 32'h108;
    push_d_read(32'hCAFE_0108);
    wait_hits(1, 20);
    check("rec_addr", {32'b0, last_addr}, 64'h108);
    tick();
    dmemREN = 1'b0;
    tick();

`ifdef IFETCH_BUF_EN
    // first fetch of 0x40 goes to RAM and fills the buffer
    mem[32'h40] = 32'h0000_4040;
    imemREN = 1'b1;
    imemaddr = 32'h40;
    push_i(32'h0000_4040);
    wait_hits(1, 20);
    tick();
    imemREN = 1'b0;
    tick();
    // repeat fetch: answered in the request cycle, no RAM strobe
    imemREN = 1'b1;
    push_i(32'h0000_4040);
    @(negedge CLK);
    check("buf_ihit", {63'b0, ihit}, 64'd1);
    check("buf_ren", {63'b0, ramREN}, 64'd0);
    #1;
    imemREN = 1'b0;
    tick();
    // store to the buffered word invalidates it
    dmemWEN = 1'b1;
    dmemaddr = 32'h40;
    dmemstore = 32'h77;
    push_d_write();
    wait_hits(1, 20);
    tick();
    dmemWEN = 1'b0;
    tick();
    imemREN = 1'b1;
    imemaddr = 32'h40;
    push_i(32'h77);
    wait_strobe(5);
    check("buf_inv_ren", {63'b0, ramREN}, 64'd1);
    wait_hits(1, 20);
    tick();
    imemREN = 1'b0;
`endif

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
